gshare_btb_predictor: RTL and testbench

Parametrised next-generation branch predictor for the fetch stage: a gshare pattern history table (saturating counters indexed by PC XOR global history) plus a tagged, direct-mapped branch target buffer. It gives a same-cycle prediction to fetch and is trained by the EX stage when a branch resolves. It keeps a speculative global history register (GHR) with checkpoint-based recovery on mispredict, and saturating lookup/mispredict statistics counters.

---
 rtl/gshare_btb_predictor.sv | 121 ++++++++++++
 tb/tb_gshare_btb_predictor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: gshare direction predictor plus tagged direct-mapped BTB.
//
// Fetch side:  pred_valid_i/pred_pc_i look up the PHT (indexed by PC XOR GHR) and the BTB in the
//              same cycle; pred_taken_o/pred_hit_o/pred_target_o are combinational, pred_ghr_o is
//              the GHR before this prediction's speculative shift.
// EX side:     upd_valid_i trains the PHT counter selected by upd_pc_i XOR upd_ghr_i, writes the
//              BTB on taken branches, and on upd_mispredict_i repairs the GHR from upd_ghr_i.
// Statistics:  stat_lookups_o / stat_mispredicts_o, 16-bit saturating.
// Reset:       rst_n, asynchronous active-low.
module gshare_btb_predictor #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned HIST_W = 4,
  parameter int unsigned CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid_i,
  input  logic [PC_W-1:0]   pred_pc_i,
  output logic              pred_taken_o,
  output logic              pred_hit_o,
  output logic [PC_W-1:0]   pred_target_o,
  output logic [HIST_W-1:0] pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [PC_W-1:0]   upd_target_i,
  input  logic [HIST_W-1:0] upd_ghr_i,
  input  logic              upd_mispredict_i,
  output logic [15:0]       stat_lookups_o,
  output logic [15:0]       stat_mispredicts_o
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned TagW    = PC_W - IDX_W;
  // Weak-not-taken; evaluates to 0 when CTR_W == 1.
  localparam logic [CTR_W-1:0] CtrInit = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CtrMax  = {CTR_W{1'b1}};

  logic [CTR_W-1:0]  pht_q        [Entries];
  logic [Entries-1:0] btb_valid_q;
  logic [TagW-1:0]   btb_tag_q    [Entries];
  logic [PC_W-1:0]   btb_target_q [Entries];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [15:0]       lookups_q, lookups_d;
  logic [15:0]       mispred_q, mispred_d;

  logic [IDX_W-1:0]  pred_idx, pred_pidx, upd_idx, upd_pidx;
  logic [TagW-1:0]   pred_tag, upd_tag;
  logic [CTR_W-1:0]  upd_ctr, upd_ctr_d;
  logic              recover;

  // Lookup path.
  always_comb begin
    pred_idx      = pred_pc_i[IDX_W-1:0];
    pred_tag      = pred_pc_i[PC_W-1:IDX_W];
    pred_pidx     = pred_idx ^ IDX_W'(ghr_q);
    pred_hit_o    = btb_valid_q[pred_idx] && (btb_tag_q[pred_idx] == pred_tag);
    pred_taken_o  = pred_hit_o && pht_q[pred_pidx][CTR_W-1];
    pred_target_o = pred_taken_o ? btb_target_q[pred_idx] : pred_pc_i + PC_W'(1);
    pred_ghr_o    = ghr_q;
  end

  // Training path and next-state for history and statistics.
  always_comb begin
    upd_idx   = upd_pc_i[IDX_W-1:0];
    upd_tag   = upd_pc_i[PC_W-1:IDX_W];
    upd_pidx  = upd_idx ^ IDX_W'(upd_ghr_i);
    upd_ctr   = pht_q[upd_pidx];
    upd_ctr_d = upd_ctr;
    if (upd_taken_i && (upd_ctr != CtrMax)) begin
      upd_ctr_d = upd_ctr + CTR_W'(1);
    end else if (!upd_taken_i && (upd_ctr != '0)) begin
      upd_ctr_d = upd_ctr - CTR_W'(1);
    end

    recover = upd_valid_i && upd_mispredict_i;
    // Shift-in via a truncating cast so HIST_W == 1 needs no special case.
    ghr_d = ghr_q;
    if (recover) begin
      ghr_d = HIST_W'({upd_ghr_i, upd_taken_i});
    end else if (pred_valid_i) begin
      ghr_d = HIST_W'({ghr_q, pred_taken_o});
    end

    lookups_d = lookups_q;
    if (pred_valid_i && (lookups_q != 16'hFFFF)) lookups_d = lookups_q + 16'd1;
    mispred_d = mispred_q;
    if (recover && (mispred_q != 16'hFFFF)) mispred_d = mispred_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        pht_q[i]        <= CtrInit;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
      btb_valid_q <= '0;
      ghr_q       <= '0;
      lookups_q   <= '0;
      mispred_q   <= '0;
    end else begin
      if (upd_valid_i) begin
        pht_q[upd_pidx] <= upd_ctr_d;
        if (upd_taken_i) begin
          btb_valid_q[upd_idx]  <= 1'b1;
          btb_tag_q[upd_idx]    <= upd_tag;
          btb_target_q[upd_idx] <= upd_target_i;
        end
      end
      ghr_q     <= ghr_d;
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups_o     = lookups_q;
  assign stat_mispredicts_o = mispred_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed self-checking bench for gshare_btb_predictor with default parameters.
module tb_gshare_btb_predictor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid;
  logic [7:0] pred_pc;
  logic       pred_taken, pred_hit;
  logic [7:0] pred_target;
  logic [3:0] pred_ghr;
  logic       upd_valid, upd_taken, upd_mispredict;
  logic [7:0] upd_pc, upd_target;
  logic [3:0] upd_ghr;
  logic [15:0] stat_lookups, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  gshare_btb_predictor #(.PC_W(8), .IDX_W(4), .HIST_W(4), .CTR_W(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pred_valid_i       (pred_valid),
    .pred_pc_i          (pred_pc),
    .pred_taken_o       (pred_taken),
    .pred_hit_o         (pred_hit),
    .pred_target_o      (pred_target),
    .pred_ghr_o         (pred_ghr),
    .upd_valid_i        (upd_valid),
    .upd_pc_i           (upd_pc),
    .upd_taken_i        (upd_taken),
    .upd_target_i       (upd_target),
    .upd_ghr_i          (upd_ghr),
    .upd_mispredict_i   (upd_mispredict),
    .stat_lookups_o     (stat_lookups),
    .stat_mispredicts_o (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0; pred_pc = 8'h00;
    upd_valid = 1'b0; upd_pc = 8'h00; upd_taken = 1'b0; upd_target = 8'h00;
    upd_ghr = 4'h0; upd_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one update for a single cycle (stimulus only).
  task automatic send_upd(input logic [7:0] pc, input logic tk, input logic [7:0] tgt,
                          input logic [3:0] gh, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_ghr = gh;
    upd_mispredict = mis;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    pred_valid = 1'b1; pred_pc = 8'h2F;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_taken got %h exp 0", pred_taken); end
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %h exp 0", pred_hit); end
    checks++; if (pred_target !== 8'h30) begin errors++; $display("FAIL rst_target got %h exp 30", pred_target); end
    checks++; if (pred_ghr !== 4'h0) begin errors++; $display("FAIL rst_ghr got %h exp 0", pred_ghr); end
    checks++; if (stat_mispredicts !== 16'h0) begin errors++; $display("FAIL rst_misp got %h exp 0", stat_mispredicts); end
    tick();
    pred_valid = 1'b0; pred_pc = 8'hFF;
    #1;
    checks++; if (pred_ghr !== 4'b0000) begin errors++; $display("FAIL rst_ghr_next got %b exp 0000", pred_ghr); end
    checks++; if (stat_lookups !== 16'd1) begin errors++; $display("FAIL rst_lookups got %h exp 1", stat_lookups); end
    checks++; if (pred_target !== 8'h00) begin errors++; $display("FAIL rst_wrap got %h exp 00", pred_target); end
  endtask

  task automatic test_train();
    do_reset();
    pred_pc = 8'h13;
    upd_valid = 1'b1; upd_pc = 8'h13; upd_taken = 1'b1; upd_target = 8'h40; upd_ghr = 4'h0;
    #1;
    // Update not yet applied: lookup sees the empty BTB.
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL train_same_cycle_hit got %h exp 0", pred_hit); end
    tick();
    send_upd(8'h13, 1'b1, 8'h40, 4'h0, 1'b0);
    pred_valid = 1'b1; pred_pc = 8'h13;
    #1;
    checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL train_hit got %h exp 1", pred_hit); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_taken got %h exp 1", pred_taken); end
    checks++; if (pred_target !== 8'h40) begin errors++; $display("FAIL train_target got %h exp 40", pred_target); end
    tick();
    pred_valid = 1'b0;
    #1;
    checks++; if (pred_ghr !== 4'b0001) begin errors++; $display("FAIL train_ghr got %b exp 0001", pred_ghr); end
    checks++; if (stat_lookups !== 16'd1) begin errors++; $display("FAIL train_lookups got %h exp 1", stat_lookups); end
  endtask

  task automatic test_alias();
    // Continues from test_train: GHR=0001, PHT[3]=11, BTB[3]={tag 1, 40}.
    send_upd(8'h05, 1'b0, 8'h00, 4'h0, 1'b1);
    #1;
    checks++; if (pred_ghr !== 4'b0000) begin errors++; $display("FAIL alias_ghr got %b exp 0000", pred_ghr); end
    checks++; if (stat_mispredicts !== 16'd1) begin errors++; $display("FAIL alias_misp got %h exp 1", stat_mispredicts); end
    pred_pc = 8'h23;
    #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_hit got %h exp 0", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_taken got %h exp 0", pred_taken); end
    checks++; if (pred_target !== 8'h24) begin errors++; $display("FAIL alias_target got %h exp 24", pred_target); end
    send_upd(8'h23, 1'b1, 8'h80, 4'h0, 1'b0);
    pred_pc = 8'h13;
    #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_evict_hit got %h exp 0", pred_hit); end
    checks++; if (pred_target !== 8'h14) begin errors++; $display("FAIL alias_evict_target got %h exp 14", pred_target); end
    pred_pc = 8'h23;
    #1;
    checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL alias_new_hit got %h exp 1", pred_hit); end
    checks++; if (pred_target !== 8'h80) begin errors++; $display("FAIL alias_new_target got %h exp 80", pred_target); end
  endtask

  task automatic test_recovery();
    do_reset();
    send_upd(8'h05, 1'b1, 8'h60, 4'b0101, 1'b1);
    #1;
    checks++; if (pred_ghr !== 4'b1011) begin errors++; $display("FAIL rec_setup_ghr got %b exp 1011", pred_ghr); end
    pred_valid = 1'b1; pred_pc = 8'h00;
    send_upd(8'h05, 1'b1, 8'h60, 4'b0110, 1'b1);
    pred_valid = 1'b0;
    #1;
    checks++; if (pred_ghr !== 4'b1101) begin errors++; $display("FAIL rec_ghr got %b exp 1101", pred_ghr); end
    checks++; if (stat_mispredicts !== 16'd2) begin errors++; $display("FAIL rec_misp got %h exp 2", stat_mispredicts); end
    checks++; if (stat_lookups !== 16'd1) begin errors++; $display("FAIL rec_lookups got %h exp 1", stat_lookups); end
    // GHR=1101, pc 05 -> PHT[8] still weak-not-taken, BTB[5] hits.
    pred_valid = 1'b1; pred_pc = 8'h05;
    #1;
    checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL rec_hit got %h exp 1", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rec_taken got %h exp 0", pred_taken); end
    checks++; if (pred_target !== 8'h06) begin errors++; $display("FAIL rec_target got %h exp 06", pred_target); end
    tick();
    pred_valid = 1'b0;
    #1;
    checks++; if (pred_ghr !== 4'b1010) begin errors++; $display("FAIL rec_shift_ghr got %b exp 1010", pred_ghr); end
  endtask

  task automatic test_saturation();
    do_reset();
    send_upd(8'h13, 1'b1, 8'h40, 4'h0, 1'b0);
    send_upd(8'h13, 1'b1, 8'h40, 4'h0, 1'b0);
    repeat (3) send_upd(8'h13, 1'b0, 8'h00, 4'h0, 1'b0);
    pred_pc = 8'h13;
    #1;
    checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL sat_hit got %h exp 1", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_taken got %h exp 0", pred_taken); end
    checks++; if (pred_target !== 8'h14) begin errors++; $display("FAIL sat_target got %h exp 14", pred_target); end
    send_upd(8'h13, 1'b0, 8'h00, 4'h0, 1'b0);
    send_upd(8'h13, 1'b1, 8'h40, 4'h0, 1'b0);
    #1;
    // 00 stays 00, then one taken gives 01 (still not taken).
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor_taken got %h exp 0", pred_taken); end
    send_upd(8'h13, 1'b1, 8'h40, 4'h0, 1'b0);
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_up_taken got %h exp 1", pred_taken); end
    checks++; if (pred_target !== 8'h40) begin errors++; $display("FAIL sat_up_target got %h exp 40", pred_target); end

    do_reset();
    pred_valid = 1'b1; pred_pc = 8'h13;
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_pc = 8'h00; upd_taken = 1'b0; upd_ghr = 4'h0;
    repeat (65534) tick();
    checks++; if (stat_mispredicts !== 16'hFFFE) begin errors++; $display("FAIL sat_misp_fffe got %h exp fffe", stat_mispredicts); end
    checks++; if (stat_lookups !== 16'hFFFE) begin errors++; $display("FAIL sat_look_fffe got %h exp fffe", stat_lookups); end
    tick();
    checks++; if (stat_mispredicts !== 16'hFFFF) begin errors++; $display("FAIL sat_misp_ffff got %h exp ffff", stat_mispredicts); end
    checks++; if (stat_lookups !== 16'hFFFF) begin errors++; $display("FAIL sat_look_ffff got %h exp ffff", stat_lookups); end
    repeat (3) tick();
    checks++; if (stat_mispredicts !== 16'hFFFF) begin errors++; $display("FAIL sat_misp_hold got %h exp ffff", stat_mispredicts); end
    checks++; if (stat_lookups !== 16'hFFFF) begin errors++; $display("FAIL sat_look_hold got %h exp ffff", stat_lookups); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    pred_valid = 1'b1; pred_pc = 8'h13;
    send_upd(8'h13, 1'b1, 8'h40, 4'h0, 1'b1);
    pred_valid = 1'b0;
    #1;
    checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL mid_pre_hit got %h exp 1", pred_hit); end
    checks++; if (pred_ghr !== 4'b0001) begin errors++; $display("FAIL mid_pre_ghr got %b exp 0001", pred_ghr); end
    checks++; if (stat_lookups !== 16'd1) begin errors++; $display("FAIL mid_pre_look got %h exp 1", stat_lookups); end
    checks++; if (stat_mispredicts !== 16'd1) begin errors++; $display("FAIL mid_pre_misp got %h exp 1", stat_mispredicts); end
    pred_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 8'h13; upd_taken = 1'b1; upd_target = 8'h50; upd_ghr = 4'b0111;
    upd_mispredict = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL mid_hit got %h exp 0", pred_hit); end
    checks++; if (pred_ghr !== 4'b0000) begin errors++; $display("FAIL mid_ghr got %b exp 0000", pred_ghr); end
    checks++; if (stat_lookups !== 16'd0) begin errors++; $display("FAIL mid_look got %h exp 0", stat_lookups); end
    checks++; if (stat_mispredicts !== 16'd0) begin errors++; $display("FAIL mid_misp got %h exp 0", stat_mispredicts); end
    tick();
    idle();
    pred_pc = 8'h13;
    rst_n = 1'b1;
    tick();
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL mid_lost_hit got %h exp 0", pred_hit); end
    checks++; if (pred_target !== 8'h14) begin errors++; $display("FAIL mid_lost_target got %h exp 14", pred_target); end
    checks++; if (pred_ghr !== 4'b0000) begin errors++; $display("FAIL mid_lost_ghr got %b exp 0000", pred_ghr); end
    checks++; if (stat_mispredicts !== 16'd0) begin errors++; $display("FAIL mid_lost_misp got %h exp 0", stat_mispredicts); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_train();
    test_alias();
    test_recovery();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
